alu_iterative: RTL

//  Parametrised successor ALU for the RV32IM datapath: WIDTH-bit operands, registered result.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_base_comb.sv | 34 +++
 rtl/alu_iterative.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode encoding and opcode-class helpers shared by the ALU and its users.
// Codes 0..9 keep the encoding of the existing single-cycle ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_AND    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_rem(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Single-cycle base operations (ADD..SRA); unknown opcodes yield zero.
module alu_base_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = operand_b[SHAMT_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_SLT:  result[0] = $signed(operand_a) < $signed(operand_b);
            ALU_SLTU: result[0] = operand_a < operand_b;
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_AND:  result = operand_a & operand_b;
            ALU_SLL:  result = operand_a << shamt;
            ALU_SRL:  result = operand_a >> shamt;
            ALU_SRA:  result = WIDTH'($signed(operand_a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// RV32IM ALU: base ops in one cycle, MUL*/DIV*/REM* by radix-2 iteration on magnitudes.
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | apply sign / pick half / boundary result
// DONE  | result valid, waiting for i_ready
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_alu_data,
    output logic             o_busy
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, mcand_q;
    logic [WIDTH-1:0]   special_val_q, result_q;
    logic               neg_q, special_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic               accept;
    logic               neg_a, neg_b, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b, base_y, fix_y;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    alu_base_comb #(.WIDTH(WIDTH)) u_base (
        .op        (i_alu_op),
        .operand_a (i_operand_a),
        .operand_b (i_operand_b),
        .result    (base_y)
    );

    assign accept = i_valid && (state_q == S_IDLE);

    assign neg_a    = is_signed_a(i_alu_op) && i_operand_a[WIDTH-1];
    assign neg_b    = is_signed_b(i_alu_op) && i_operand_b[WIDTH-1];
    assign mag_a    = neg_a ? -i_operand_a : i_operand_a;
    assign mag_b    = neg_b ? -i_operand_b : i_operand_b;
    assign div_zero = (i_operand_b == '0);
    assign div_ovf  = is_signed_b(i_alu_op) && (i_operand_a == MIN_INT) && (i_operand_b == '1);

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign prod_s = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_s  = neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_s  = neg_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        fix_y = '0;
        if (special_q) begin
            fix_y = special_val_q;
        end else begin
            case (op_q)
                ALU_MUL:                        fix_y = prod_s[WIDTH-1:0];
                ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_y = prod_s[2*WIDTH-1:WIDTH];
                ALU_DIV, ALU_DIVU:              fix_y = quo_s;
                ALU_REM, ALU_REMU:              fix_y = rem_s;
                default:                        fix_y = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (!is_muldiv(i_alu_op)) state_d = S_DONE;
                    else if (is_div(i_alu_op)) state_d = S_DIV;
                    else                       state_d = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                o_busy = 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                o_busy  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Boundary results are latched at accept; the iteration still runs for fixed latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q          <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            mcand_q       <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q      <= i_alu_op;
                    cnt_q     <= SHAMT_W'(WIDTH - 1);
                    acc_hi_q  <= '0;
                    special_q <= is_div(i_alu_op) && (div_zero || div_ovf);
                    if (is_rem(i_alu_op)) begin
                        neg_q         <= neg_a;
                        special_val_q <= div_zero ? i_operand_a : '0;
                    end else begin
                        neg_q         <= neg_a ^ neg_b;
                        special_val_q <= div_zero ? '1 : MIN_INT;
                    end
                    if (is_div(i_alu_op)) begin
                        acc_lo_q <= mag_a;
                        mcand_q  <= mag_b;
                    end else begin
                        acc_lo_q <= mag_b;
                        mcand_q  <= mag_a;
                    end
                end
                S_MUL: begin
                    {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                    cnt_q                <= cnt_q - 1'b1;
                end
                S_DIV: begin
                    acc_hi_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    cnt_q    <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                                     result_q <= '0;
        else if (accept && !is_muldiv(i_alu_op))        result_q <= base_y;
        else if (state_q == S_FIX)                      result_q <= fix_y;
    end

    assign o_alu_data = result_q;

endmodule
